// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: data width, divider FSM states and counter width.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DIV_CNT_W  = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    CORRECT,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring division step on {P, Q} against an unsigned divisor.
module div_nr_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] d_ext;

  // Add/subtract is chosen by the sign of P before the shift; WIDTH+1 bits hold the
  // settled P in [-D, D) even though the shifted intermediate may wrap.
  always_comb begin
    p_shift = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
    d_ext   = {1'b0, d_i};
    p_o     = p_i[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
    q_o     = {q_i[WIDTH-2:0], ~p_o[WIDTH]};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring divider producing {remainder, quotient} for the Z register.
// Define SEQ_DIVIDER_SIGNED_EN for signed two's-complement division; default is unsigned.
module seq_divider
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] z_out
);

  div_state_t state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]       p_q, p_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic                 qs_q, qs_d;
  logic                 rs_q, rs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic [2*WIDTH-1:0]   z_q, z_d;

  logic [WIDTH:0]   step_p;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH:0]   rem_fix;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;

  div_nr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p_i(p_q),
    .q_i(q_q),
    .d_i(d_q),
    .p_o(step_p),
    .q_o(step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    dbz_d   = dbz_q;
    z_d     = z_q;
    rem_fix = p_q;
    rem_w   = '0;
    quo_w   = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Raw operands land in q/d; LOAD converts them to magnitudes in place.
          q_d     = dividend;
          d_d     = divisor;
          dbz_d   = 1'b0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (d_q == '0) begin
          z_d     = {q_q, {WIDTH{1'b1}}};
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          qs_d = q_q[WIDTH-1] ^ d_q[WIDTH-1];
          rs_d = q_q[WIDTH-1];
          q_d  = q_q[WIDTH-1] ? (~q_q + 1'b1) : q_q;
          d_d  = d_q[WIDTH-1] ? (~d_q + 1'b1) : d_q;
`else
          qs_d = 1'b0;
          rs_d = 1'b0;
`endif
          p_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        p_d   = step_p;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
          state_d = CORRECT;
        end
      end
      CORRECT: begin
        rem_fix = p_q[WIDTH] ? (p_q + {1'b0, d_q}) : p_q;
        rem_w   = rem_fix[WIDTH-1:0];
        quo_w   = q_q;
        if (qs_q) quo_w = ~quo_w + 1'b1;
        if (rs_q) rem_w = ~rem_w + 1'b1;
        z_d     = {rem_w, quo_w};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD) || (state_d == ITER) || (state_d == CORRECT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      z_q     <= z_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign z_out       = z_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] z_out;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  always #5 Clock = ~Clock;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .Clock(Clock),
    .Clear(Clear),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .z_out(z_out)
  );

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_DIVIDER_SIGNED_EN
    longint sa;
    longint sb;
    logic [63:0] qv;
    logic [63:0] rv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qv = 64'(sa / sb);
    rv = 64'(sa % sb);
    return {rv[31:0], qv[31:0]};
`else
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: result computed arithmetically, released after the latency.
  logic        m_busy, m_done, m_dbz, m_pdbz;
  logic [63:0] m_z, m_res;
  int          m_left;

  always @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_pdbz <= 1'b0;
      m_z    <= '0;
      m_res  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && start) begin
        m_busy <= 1'b1;
        m_dbz  <= 1'b0;
        m_res  <= ref_div(dividend, divisor);
        m_pdbz <= (divisor == 32'd0);
        m_left <= (divisor == 32'd0) ? 1 : int'(W) + 2;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_z    <= m_res;
          m_dbz  <= m_pdbz;
        end
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge Clock) begin
    if (checking && !Clear) begin
      check("cmp_busy", 64'(busy), 64'(m_busy));
      check("cmp_done", 64'(done), 64'(m_done));
      check("cmp_dbz", 64'(div_by_zero), 64'(m_dbz));
      if (!m_busy) check("cmp_z", z_out, m_z);
    end
  end

  // Call mid-cycle; returns 1 ns after the edge where done is first seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_z,
                        input int exp_lat, input bit poke, input string name);
    int k;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge Clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check({name, "_dbz_clr"}, 64'(div_by_zero), 64'd0);
    k = 0;
    while (!done && k < 100) begin
      check({name, "_busy"}, 64'(busy), 64'd1);
      if (poke && k == 5) begin
        start    = 1'b1;
        dividend = 32'h1111_1111;
        divisor  = 32'h0000_0003;
      end
      @(posedge Clock);
      #1;
      start = 1'b0;
      k++;
    end
    check({name, "_lat"}, 64'(k), 64'(exp_lat));
    check({name, "_z"}, z_out, exp_z);
    check({name, "_dbz"}, 64'(div_by_zero), 64'(b == 32'd0));
    check({name, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [31:0] a, b;
    int sel;
    #2 Clear = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_z", z_out, 64'd0);
    @(negedge Clock);
    Clear    = 1'b0;
    checking = 1'b1;

    run_op(32'h22, 32'h24, {32'h22, 32'h0}, 34, 1'b0, "d22_24");
    idle(2);
    run_op(32'd100, 32'd7, {32'h2, 32'hE}, 34, 1'b0, "d100_7");
`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 1'b0, "b2b_m7_2");
    idle(1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 1'b0, "ovf");
`else
    run_op(32'hFFFF_FFF9, 32'd2, {32'h1, 32'h7FFF_FFFC}, 34, 1'b0, "b2b_m7_2");
    idle(1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 34, 1'b0, "ovf");
`endif
    idle(1);
    run_op(32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, 1, 1'b0, "dbz");
`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'h0}, 34, 1'b0, "after_dbz");
`else
    run_op(32'hFFFF_FFFF, 32'd2, {32'h1, 32'h7FFF_FFFF}, 34, 1'b0, "after_dbz");
`endif
    idle(1);
    run_op(32'd100, 32'd7, {32'h2, 32'hE}, 34, 1'b1, "poke");
    idle(1);

    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge Clock);
    #1 start = 1'b0;
    repeat (11) @(posedge Clock);
    #2 Clear = 1'b1;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_z", z_out, 64'd0);
    @(posedge Clock);
    #2 Clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock);
      #1 check("clr_no_done", 64'(done), 64'd0);
    end
    run_op(32'd1000, 32'd33, ref_div(32'd1000, 32'd33), 34, 1'b0, "post_clr");

    for (int n = 0; n < 40; n++) begin
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: b = a;
        default: b = $urandom;
      endcase
      run_op(a, b, ref_div(a, b), (b == 32'd0) ? 1 : 34, ($urandom_range(0, 3) == 0), "rnd");
      sel = $urandom_range(0, 2);
      if (sel != 0) idle(sel);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
